load_fifo: RTL

- First-word-fall-through buffer that sits directly upstream of the 64-bit datapath Register.
- Accepts words from a producer using a valid/ready handshake.
- Presents the oldest word on the Register's data input and asserts the Register's load strobe exactly once per word.
- Decouples producer bursts from the cycles in which the downstream register may be overwritten, which are signalled by `take`.

---
 rtl/load_fifo_pkg.sv | 7 +
 rtl/load_fifo_mem.sv | 27 ++
 rtl/load_fifo.sv | 81 ++++++++
 3 files changed

// File: rtl/load_fifo_pkg.sv
// Shared constants for the 64-bit datapath register and the FIFO that feeds it.
package load_fifo_pkg;

    localparam int WORD_W          = 64;
    localparam int LOAD_FIFO_DEPTH = 4;

endpackage : load_fifo_pkg

// File: rtl/load_fifo_mem.sv
// DEPTH x WIDTH storage for load_fifo: one synchronous write port, one asynchronous read port.
module load_fifo_mem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the pointers and count in the parent decide
    // which entries are live, so clearing the array would only cost area.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : load_fifo_mem

// File: rtl/load_fifo.sv
// First-word-fall-through buffer that presents the oldest word to the datapath
// register and strobes its load once per word whenever downstream allows (take).
module load_fifo
    import load_fifo_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = LOAD_FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic             take,
    output logic [WIDTH-1:0] I,
    output logic             ld,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             clear;

    // in_ready depends only on registered occupancy, never on take.
    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = take && !empty;
    assign clear    = rst || flush;

    assign ld    = pop;
    assign count = cnt;
    assign I     = empty ? '0 : head;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // A push coinciding with flush or reset is dropped, so it is not written either.
    load_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !clear),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

endmodule : load_fifo
